// File: rtl/ls_ex_queue.sv
// Load/store execution queue: in-order FIFO of memory ops feeding a single
// outstanding memctrl transaction, with rollback that kills queued loads.
module ls_ex_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   // enqueue side
   input  logic              enable_sign_from_ls,
   input  logic              is_store_from_ls,
   input  logic [1:0]        size_from_ls,
   input  logic              unsigned_from_ls,
   input  logic [TAG_W-1:0]  tag_from_ls,
   input  logic [ADDR_W-1:0] address_from_ls,
   input  logic [DATA_W-1:0] store_data_from_ls,
   output logic              full_sign_to_ls,
   // memory controller side
   output logic              enable_sign_to_memctrl,
   output logic [ADDR_W-1:0] address_to_memctrl,
   output logic [DATA_W-1:0] store_data_to_memctrl,
   output logic [2:0]        size_to_memctrl,
   output logic              load_store_sign_to_memctrl,
   input  logic              finish_sign_from_memctrl,
   input  logic [DATA_W-1:0] load_data_from_memctrl,
   // rollback
   input  logic              rollback_sign_from_rob,
   // load result
   output logic              valid_sign,
   output logic [DATA_W-1:0] data,
   output logic [TAG_W-1:0]  tag
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StWaitMem} state_t;

   state_t r_state, w_state_d;

   // queue storage
   logic              r_is_store [DEPTH];
   logic [1:0]        r_size     [DEPTH];
   logic              r_unsigned [DEPTH];
   logic [TAG_W-1:0]  r_tag      [DEPTH];
   logic [ADDR_W-1:0] r_addr     [DEPTH];
   logic [DATA_W-1:0] r_sdata    [DEPTH];
   logic [DEPTH-1:0]  r_killed;

   logic [PTR_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;

   // registered outputs
   logic              r_mem_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_sdata;
   logic [2:0]        r_mem_size;
   logic              r_mem_store;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [TAG_W-1:0]  r_res_tag;

   logic              w_enq, w_issue, w_skip, w_complete, w_pop;
   logic [2:0]        w_head_bytes;
   logic [DATA_W-1:0] w_load_ext;

   assign full_sign_to_ls            = (r_count >= FULL_C);
   assign enable_sign_to_memctrl     = r_mem_en;
   assign address_to_memctrl         = r_mem_addr;
   assign store_data_to_memctrl      = r_mem_sdata;
   assign size_to_memctrl            = r_mem_size;
   assign load_store_sign_to_memctrl = r_mem_store;
   assign valid_sign                 = r_valid;
   assign data                       = r_data;
   assign tag                        = r_res_tag;

   // A load arriving together with rollback is already squashed; stores are committed.
   assign w_enq = rdy & enable_sign_from_ls & (r_count < DEPTH_C) &
                  (is_store_from_ls | ~rollback_sign_from_rob);
   assign w_pop = w_skip | w_complete;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else if (rdy) begin
         r_state <= w_state_d;
      end
   end

   // FSM next state: issue live head, drop killed head, wait for memctrl finish
   always_comb begin
      w_state_d  = r_state;
      w_issue    = 1'b0;
      w_skip     = 1'b0;
      w_complete = 1'b0;
      if (rdy) begin
         case (r_state)
            StIdle: begin
               if (r_count != '0) begin
                  if (r_killed[r_head]) begin
                     w_skip = 1'b1;
                  end else begin
                     w_issue   = 1'b1;
                     w_state_d = StWaitMem;
                  end
               end
            end
            StWaitMem: begin
               if (finish_sign_from_memctrl) begin
                  w_complete = 1'b1;
                  w_state_d  = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Byte count of the head entry; encoding 3 behaves as a word
   always_comb begin
      case (r_size[r_head])
         2'd0:    w_head_bytes = 3'd1;
         2'd1:    w_head_bytes = 3'd2;
         default: w_head_bytes = 3'd4;
      endcase
   end

   // Sign/zero extension of the returned load data for the head entry
   always_comb begin
      w_load_ext = load_data_from_memctrl;
      case (r_size[r_head])
         2'd0: w_load_ext = {{(DATA_W-8){~r_unsigned[r_head] & load_data_from_memctrl[7]}},
                             load_data_from_memctrl[7:0]};
         2'd1: w_load_ext = {{(DATA_W-16){~r_unsigned[r_head] & load_data_from_memctrl[15]}},
                             load_data_from_memctrl[15:0]};
         default: w_load_ext = load_data_from_memctrl;
      endcase
   end

   // Queue storage, pointers, memctrl request and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_is_store[i] <= 1'b0;
            r_size[i]     <= '0;
            r_unsigned[i] <= 1'b0;
            r_tag[i]      <= '0;
            r_addr[i]     <= '0;
            r_sdata[i]    <= '0;
         end
         r_killed    <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_mem_en    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_sdata <= '0;
         r_mem_size  <= '0;
         r_mem_store <= 1'b0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_res_tag   <= '0;
      end else if (rdy) begin
         r_valid <= 1'b0;

         // kill loads before the enqueue write so a new entry is never marked
         if (rollback_sign_from_rob) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (!r_is_store[i]) r_killed[i] <= 1'b1;
            end
         end

         if (w_enq) begin
            r_is_store[r_tail] <= is_store_from_ls;
            r_size[r_tail]     <= size_from_ls;
            r_unsigned[r_tail] <= unsigned_from_ls;
            r_tag[r_tail]      <= tag_from_ls;
            r_addr[r_tail]     <= address_from_ls;
            r_sdata[r_tail]    <= store_data_from_ls;
            r_killed[r_tail]   <= 1'b0;
            r_tail             <= r_tail + 1'b1;
         end

         if (w_pop) r_head <= r_head + 1'b1;

         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_issue) begin
            r_mem_en    <= 1'b1;
            r_mem_addr  <= r_addr[r_head];
            r_mem_sdata <= r_sdata[r_head];
            r_mem_size  <= w_head_bytes;
            r_mem_store <= r_is_store[r_head];
         end

         if (w_complete) begin
            r_mem_en <= 1'b0;
            // a load killed while in flight still finishes but reports nothing
            if (!r_is_store[r_head] && !r_killed[r_head] && !rollback_sign_from_rob) begin
               r_valid   <= 1'b1;
               r_data    <= w_load_ext;
               r_res_tag <= r_tag[r_head];
            end
         end
      end
   end

endmodule

// File: tb/tb_ls_ex_queue.sv
// Directed self-checking bench for ls_ex_queue (DEPTH=4, 32-bit address/data).
module tb_ls_ex_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        enable_sign_from_ls;
   logic        is_store_from_ls;
   logic [1:0]  size_from_ls;
   logic        unsigned_from_ls;
   logic [3:0]  tag_from_ls;
   logic [31:0] address_from_ls;
   logic [31:0] store_data_from_ls;
   logic        full_sign_to_ls;
   logic        enable_sign_to_memctrl;
   logic [31:0] address_to_memctrl;
   logic [31:0] store_data_to_memctrl;
   logic [2:0]  size_to_memctrl;
   logic        load_store_sign_to_memctrl;
   logic        finish_sign_from_memctrl;
   logic [31:0] load_data_from_memctrl;
   logic        rollback_sign_from_rob;
   logic        valid_sign;
   logic [31:0] data;
   logic [3:0]  tag;

   int n_cmp = 0;
   int n_err = 0;

   ls_ex_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TAG_W(4)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .rdy                        (rdy),
      .enable_sign_from_ls        (enable_sign_from_ls),
      .is_store_from_ls           (is_store_from_ls),
      .size_from_ls               (size_from_ls),
      .unsigned_from_ls           (unsigned_from_ls),
      .tag_from_ls                (tag_from_ls),
      .address_from_ls            (address_from_ls),
      .store_data_from_ls         (store_data_from_ls),
      .full_sign_to_ls            (full_sign_to_ls),
      .enable_sign_to_memctrl     (enable_sign_to_memctrl),
      .address_to_memctrl         (address_to_memctrl),
      .store_data_to_memctrl      (store_data_to_memctrl),
      .size_to_memctrl            (size_to_memctrl),
      .load_store_sign_to_memctrl (load_store_sign_to_memctrl),
      .finish_sign_from_memctrl   (finish_sign_from_memctrl),
      .load_data_from_memctrl     (load_data_from_memctrl),
      .rollback_sign_from_rob     (rollback_sign_from_rob),
      .valid_sign                 (valid_sign),
      .data                       (data),
      .tag                        (tag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // advance one rising edge, then settle before sampling or driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_enq(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd);
      enable_sign_from_ls = 1'b1;
      is_store_from_ls    = st;
      size_from_ls        = sz;
      unsigned_from_ls    = uns;
      tag_from_ls         = t;
      address_from_ls     = a;
      store_data_from_ls  = sd;
   endtask

   task automatic wait_enable(input string name);
      int w;
      w = 0;
      while (!enable_sign_to_memctrl && w < 20) begin
         tick();
         w++;
      end
      if (!enable_sign_to_memctrl) check_eq({name, "_wait_en"}, 32'(enable_sign_to_memctrl), 1);
   endtask

   // finish the outstanding load and check the single result pulse
   task automatic complete_one(input logic [3:0] t, input logic [31:0] ret);
      wait_enable("complete");
      finish_sign_from_memctrl = 1'b1;
      load_data_from_memctrl   = ret;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("cmp_valid", 32'(valid_sign), 1);
      check_eq("cmp_tag", 32'(tag), 32'(t));
      check_eq("cmp_data", data, ret);
   endtask

   // single load from an empty idle queue with full handshake and latency checks
   task automatic do_load(input logic [3:0] t, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] ret, input logic [31:0] exp,
                          input logic [2:0] bytes);
      set_enq(1'b0, sz, uns, t, a, 32'h0);
      tick();
      enable_sign_from_ls = 1'b0;
      check_eq("ld_lat1", 32'(enable_sign_to_memctrl), 0);
      tick();
      check_eq("ld_lat2", 32'(enable_sign_to_memctrl), 1);
      check_eq("ld_addr", address_to_memctrl, a);
      check_eq("ld_bytes", 32'(size_to_memctrl), 32'(bytes));
      check_eq("ld_ls", 32'(load_store_sign_to_memctrl), 0);
      finish_sign_from_memctrl = 1'b1;
      load_data_from_memctrl   = ret;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("ld_en_drop", 32'(enable_sign_to_memctrl), 0);
      check_eq("ld_valid", 32'(valid_sign), 1);
      check_eq("ld_data", data, exp);
      check_eq("ld_tag", 32'(tag), 32'(t));
      tick();
      check_eq("ld_pulse_end", 32'(valid_sign), 0);
   endtask

   initial begin
      logic seen_en, seen_v;
      rst = 1'b0;
      rdy = 1'b1;
      enable_sign_from_ls = 1'b0;
      is_store_from_ls = 1'b0;
      size_from_ls = 2'd0;
      unsigned_from_ls = 1'b0;
      tag_from_ls = 4'd0;
      address_from_ls = 32'h0;
      store_data_from_ls = 32'h0;
      finish_sign_from_memctrl = 1'b0;
      load_data_from_memctrl = 32'h0;
      rollback_sign_from_rob = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_en", 32'(enable_sign_to_memctrl), 0);
      check_eq("rst_valid", 32'(valid_sign), 0);
      check_eq("rst_data", data, 0);
      check_eq("rst_tag", 32'(tag), 0);
      check_eq("rst_addr", address_to_memctrl, 0);
      check_eq("rst_size", 32'(size_to_memctrl), 0);
      check_eq("rst_full", 32'(full_sign_to_ls), 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // extension and size encoding
      do_load(4'd1, 32'h100, 2'd0, 1'b0, 32'h0000_00F0, 32'hFFFF_FFF0, 3'd1);
      do_load(4'd2, 32'h204, 2'd1, 1'b1, 32'h0000_ABCD, 32'h0000_ABCD, 3'd2);
      do_load(4'd3, 32'h208, 2'd1, 1'b0, 32'h0000_8001, 32'hFFFF_8001, 3'd2);
      do_load(4'd4, 32'h20C, 2'd0, 1'b1, 32'h1234_56F0, 32'h0000_00F0, 3'd1);
      do_load(4'd5, 32'h210, 2'd2, 1'b0, 32'h8765_4321, 32'h8765_4321, 3'd4);
      do_load(4'd6, 32'h214, 2'd3, 1'b0, 32'h8000_0001, 32'h8000_0001, 3'd4);

      // fill with memctrl stalled: full at 3, 4th accepted, 5th dropped
      set_enq(1'b0, 2'd2, 1'b0, 4'd3, 32'h300, 32'h0);
      tick();
      check_eq("fill_full1", 32'(full_sign_to_ls), 0);
      set_enq(1'b0, 2'd2, 1'b0, 4'd4, 32'h304, 32'h0);
      tick();
      check_eq("fill_full2", 32'(full_sign_to_ls), 0);
      set_enq(1'b0, 2'd2, 1'b0, 4'd5, 32'h308, 32'h0);
      tick();
      check_eq("fill_full3", 32'(full_sign_to_ls), 1);
      set_enq(1'b0, 2'd2, 1'b0, 4'd6, 32'h30C, 32'h0);
      tick();
      check_eq("fill_full4", 32'(full_sign_to_ls), 1);
      set_enq(1'b0, 2'd2, 1'b0, 4'd7, 32'h310, 32'h0);
      tick();
      enable_sign_from_ls = 1'b0;
      check_eq("fill_addr_head", address_to_memctrl, 32'h300);
      complete_one(4'd3, 32'h0000_0033);
      complete_one(4'd4, 32'h0000_0044);
      complete_one(4'd5, 32'h0000_0055);
      complete_one(4'd6, 32'h0000_0066);
      seen_en = 1'b0;
      repeat (5) begin
         tick();
         seen_en |= enable_sign_to_memctrl;
      end
      check_eq("fill_5th_dropped", 32'(seen_en), 0);
      check_eq("fill_drained_full", 32'(full_sign_to_ls), 0);

      // {SW, LW, LW}, rollback while SW in flight
      set_enq(1'b1, 2'd2, 1'b0, 4'd8, 32'h400, 32'hDEAD_BEEF);
      tick();
      set_enq(1'b0, 2'd2, 1'b0, 4'd9, 32'h404, 32'h0);
      tick();
      set_enq(1'b0, 2'd2, 1'b0, 4'd10, 32'h408, 32'h0);
      tick();
      enable_sign_from_ls = 1'b0;
      check_eq("rb_sw_en", 32'(enable_sign_to_memctrl), 1);
      check_eq("rb_sw_ls", 32'(load_store_sign_to_memctrl), 1);
      check_eq("rb_sw_addr", address_to_memctrl, 32'h400);
      check_eq("rb_sw_sdata", store_data_to_memctrl, 32'hDEAD_BEEF);
      rollback_sign_from_rob = 1'b1;
      tick();
      rollback_sign_from_rob = 1'b0;
      check_eq("rb_sw_held", 32'(enable_sign_to_memctrl), 1);
      tick();
      finish_sign_from_memctrl = 1'b1;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("rb_sw_done_en", 32'(enable_sign_to_memctrl), 0);
      check_eq("rb_sw_no_valid", 32'(valid_sign), 0);
      seen_en = 1'b0;
      seen_v = 1'b0;
      repeat (6) begin
         tick();
         seen_en |= enable_sign_to_memctrl;
         seen_v  |= valid_sign;
      end
      check_eq("rb_loads_no_req", 32'(seen_en), 0);
      check_eq("rb_loads_no_valid", 32'(seen_v), 0);

      // rollback while LW in flight, finish three cycles later, then store issues
      set_enq(1'b0, 2'd2, 1'b0, 4'd11, 32'h500, 32'h0);
      tick();
      set_enq(1'b1, 2'd2, 1'b0, 4'd12, 32'h504, 32'h55AA_55AA);
      tick();
      enable_sign_from_ls = 1'b0;
      check_eq("rbl_addr", address_to_memctrl, 32'h500);
      rollback_sign_from_rob = 1'b1;
      tick();
      rollback_sign_from_rob = 1'b0;
      tick();
      check_eq("rbl_held", 32'(enable_sign_to_memctrl), 1);
      tick();
      finish_sign_from_memctrl = 1'b1;
      load_data_from_memctrl = 32'h0000_0077;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("rbl_en_drop", 32'(enable_sign_to_memctrl), 0);
      check_eq("rbl_no_valid", 32'(valid_sign), 0);
      tick();
      check_eq("rbl_next_en", 32'(enable_sign_to_memctrl), 1);
      check_eq("rbl_next_ls", 32'(load_store_sign_to_memctrl), 1);
      check_eq("rbl_next_addr", address_to_memctrl, 32'h504);
      finish_sign_from_memctrl = 1'b1;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("rbl_st_no_valid", 32'(valid_sign), 0);

      // rdy low mid-transaction with finish asserted
      set_enq(1'b0, 2'd2, 1'b0, 4'd13, 32'h600, 32'h0);
      tick();
      enable_sign_from_ls = 1'b0;
      tick();
      check_eq("rdy_en", 32'(enable_sign_to_memctrl), 1);
      rdy = 1'b0;
      finish_sign_from_memctrl = 1'b1;
      load_data_from_memctrl = 32'h1234_5678;
      repeat (5) tick();
      check_eq("rdy_hold_en", 32'(enable_sign_to_memctrl), 1);
      check_eq("rdy_hold_valid", 32'(valid_sign), 0);
      check_eq("rdy_hold_addr", address_to_memctrl, 32'h600);
      rdy = 1'b1;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("rdy_done_valid", 32'(valid_sign), 1);
      check_eq("rdy_done_data", data, 32'h1234_5678);
      check_eq("rdy_done_tag", 32'(tag), 13);
      check_eq("rdy_done_en", 32'(enable_sign_to_memctrl), 0);
      rdy = 1'b0;
      tick();
      check_eq("rdy_valid_held", 32'(valid_sign), 1);
      rdy = 1'b1;
      tick();
      check_eq("rdy_valid_clear", 32'(valid_sign), 0);

      // ten streamed loads, tags must come back in order across pointer wrap
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               int w;
               w = 0;
               while (full_sign_to_ls && w < 50) begin
                  tick();
                  w++;
               end
               set_enq(1'b0, 2'd2, 1'b1, 4'(i), 32'h700 + 32'(i) * 4, 32'h0);
               tick();
               enable_sign_from_ls = 1'b0;
            end
         end
         begin
            for (int j = 0; j < 10; j++) complete_one(4'(j), 32'hA000 + 32'(j));
         end
      join
      seen_en = 1'b0;
      repeat (4) begin
         tick();
         seen_en |= enable_sign_to_memctrl;
      end
      check_eq("stream_empty", 32'(seen_en), 0);

      // enqueue coinciding with rollback: load dropped, store kept
      rollback_sign_from_rob = 1'b1;
      set_enq(1'b0, 2'd2, 1'b0, 4'd14, 32'h800, 32'h0);
      tick();
      rollback_sign_from_rob = 1'b0;
      enable_sign_from_ls = 1'b0;
      seen_en = 1'b0;
      repeat (3) begin
         tick();
         seen_en |= enable_sign_to_memctrl;
      end
      check_eq("rbenq_load_dropped", 32'(seen_en), 0);
      rollback_sign_from_rob = 1'b1;
      set_enq(1'b1, 2'd2, 1'b0, 4'd14, 32'h804, 32'hCAFE_F00D);
      tick();
      rollback_sign_from_rob = 1'b0;
      enable_sign_from_ls = 1'b0;
      check_eq("rbenq_st_lat1", 32'(enable_sign_to_memctrl), 0);
      tick();
      check_eq("rbenq_st_en", 32'(enable_sign_to_memctrl), 1);
      check_eq("rbenq_st_addr", address_to_memctrl, 32'h804);
      check_eq("rbenq_st_sdata", store_data_to_memctrl, 32'hCAFE_F00D);
      finish_sign_from_memctrl = 1'b1;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("rbenq_st_no_valid", 32'(valid_sign), 0);

      // reset in the middle of a transaction, late finish ignored
      set_enq(1'b0, 2'd2, 1'b0, 4'd15, 32'h900, 32'h0);
      tick();
      enable_sign_from_ls = 1'b0;
      tick();
      check_eq("mrst_en_before", 32'(enable_sign_to_memctrl), 1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("mrst_en_async", 32'(enable_sign_to_memctrl), 0);
      check_eq("mrst_addr", address_to_memctrl, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      finish_sign_from_memctrl = 1'b1;
      load_data_from_memctrl = 32'hFFFF_FFFF;
      tick();
      finish_sign_from_memctrl = 1'b0;
      check_eq("mrst_late_valid", 32'(valid_sign), 0);
      tick();
      check_eq("mrst_late_en", 32'(enable_sign_to_memctrl), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ls_ex_queue.md
LS_EX_QUEUE -- requirements
Module: ls_ex_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, queue entries (power of 2, at least 2); ADDR_W, default 32, address width; DATA_W, default 32, data width; TAG_W, default 4, ROB tag width.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port rdy, input, 1, global enable; when low, no state changes.
REQ-005 SHALL have port enable_sign_from_ls, input, 1, enqueue request.
REQ-006 SHALL have input ports is_store_from_ls (1), size_from_ls (2: 0=byte, 1=half, 2=word), unsigned_from_ls (1), tag_from_ls (TAG_W), address_from_ls (ADDR_W), store_data_from_ls (DATA_W).
REQ-007 SHALL have port full_sign_to_ls, output, 1, backpressure.
REQ-008 SHALL have memctrl ports: enable_sign_to_memctrl out 1, address_to_memctrl out ADDR_W, store_data_to_memctrl out DATA_W, size_to_memctrl out 3 (byte count), load_store_sign_to_memctrl out 1 (1=store), finish_sign_from_memctrl in 1, load_data_from_memctrl in DATA_W.
REQ-009 SHALL have port rollback_sign_from_rob, input, 1, flush of speculative loads.
REQ-010 SHALL have result outputs: valid_sign out 1, data out DATA_W, tag out TAG_W.

Function
REQ-011 SHALL hold a circular FIFO of DEPTH entries; each entry is {is_store, size, unsigned, tag, addr, sdata, killed}; head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-012 full_sign_to_ls SHALL be combinational: 1 when count >= DEPTH-1 (one slot of slack for an in-flight enqueue).
REQ-013 Enqueue SHALL occur when rdy=1 and enable_sign_from_ls=1 and count<DEPTH; at count==DEPTH the request SHALL be dropped with no state change.
REQ-014 The FSM SHALL have two states: IDLE and WAIT_MEM.
REQ-015 In IDLE, with rdy=1 and count>0, a killed head entry SHALL be popped in one cycle with no memctrl request.
REQ-016 In IDLE, with rdy=1 and count>0, a live head entry SHALL drive enable_sign_to_memctrl=1 with its fields registered next cycle, and the FSM SHALL enter WAIT_MEM.
REQ-017 size_to_memctrl SHALL be 1/2/4 for size 0/1/2; size 3 SHALL be treated as 2.
REQ-018 In WAIT_MEM, enable and request fields SHALL be held stable until finish_sign_from_memctrl=1 is sampled.
REQ-019 On the finish cycle, the next edge SHALL drop enable to 0, pop the head, and return to IDLE; the next request SHALL issue no earlier than one cycle later.
REQ-020 Load completion SHALL set valid_sign=1 for exactly one cycle, with tag = entry tag and data = load_data_from_memctrl sign-extended (unsigned=0) or zero-extended (unsigned=1) from bit 7/15; word loads SHALL pass through.
REQ-021 Store completion SHALL produce no valid_sign pulse.
REQ-022 Latency: an enqueue into an empty idle queue SHALL raise enable 2 cycles after the enqueue edge.
REQ-023 On rollback_sign_from_rob=1 (rdy=1), all queued loads SHALL be marked killed; stores are committed and SHALL remain live; count SHALL be unchanged.
REQ-024 A load enqueued in the same cycle as rollback SHALL be dropped; a store enqueued in that cycle SHALL be accepted.
REQ-025 Rollback during WAIT_MEM on a load SHALL continue waiting for finish (memctrl is not aborted), and its result SHALL be suppressed (no valid_sign).
REQ-026 Simultaneous enqueue and pop SHALL leave count unchanged; pointers SHALL wrap correctly at DEPTH-1 -> 0.
REQ-027 When rdy=0, all registers SHALL hold, valid_sign SHALL hold its current value, and finish_sign_from_memctrl SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately clear count, pointers, FSM=IDLE, enable_sign_to_memctrl=0, valid_sign=0, data=0, tag=0, address/store_data/size/load_store_sign outputs=0, and all killed bits.
REQ-029 Reset mid-WAIT_MEM SHALL abandon the transaction; a late finish pulse after reset release SHALL be ignored while IDLE.

Verification
REQ-030 SHALL cover: LB unsigned=0 at 0x100, memctrl returns 0x000000F0 -> valid_sign pulse with data 0xFFFFFFF0; LHU with return 0x0000ABCD -> 0x0000ABCD.
REQ-031 SHALL cover: DEPTH=4, 3 enqueues with memctrl stalled -> full_sign_to_ls=1 at count 3; 4th accepted; 5th dropped; count stays 4.
REQ-032 SHALL cover: queue {SW, LW, LW}, rollback while the SW is in WAIT_MEM -> SW completes to memctrl, both loads skipped without requests, no valid_sign.
REQ-033 SHALL cover: rollback while LW is in WAIT_MEM, finish 3 cycles later -> enable drops, no valid_sign, next entry issues.
REQ-034 SHALL cover: rdy=0 for 5 cycles mid-WAIT_MEM with finish=1 -> no state change; rdy=1 -> completion proceeds.
REQ-035 SHALL cover: 10 back-to-back loads through DEPTH=4 -> tags returned in order 0..9, pointers wrap with no loss.
